// File: rtl/fc_act_loader.sv
// Activation frame loader: collects IN beats from a valid/ready stream into a
// static array and holds it for the combinational FC layer until acknowledged.
module fc_act_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_short,
    output logic             err_long,
    output logic [15:0]      frame_cnt
);
    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             s_ready_q, x_valid_q;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic [15:0]      frame_cnt_q;
    logic [WIDTH-1:0] x_q [0:IN-1];

    logic beat, rel, is_last_idx, fill_wr;

    // Handshakes use the registered ready/valid so no input reaches an output.
    assign beat        = s_valid && s_ready_q;
    assign rel         = x_valid_q && x_ready;
    assign is_last_idx = (idx_q == LAST_IDX);
    assign fill_wr     = beat && (state_q == ST_FILL);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (beat) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (s_last) begin
                        state_d     = ST_HOLD;
                        err_short_d = !is_last_idx;
                    end else if (is_last_idx) begin
                        state_d    = ST_DRAIN;
                        err_long_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && s_last) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rel) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            s_ready_q   <= 1'b0;
            x_valid_q   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s_ready_q   <= (state_d != ST_HOLD);
            x_valid_q   <= (state_d == ST_HOLD);
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            if (rel) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Short frames rely on the clear-on-release to leave the tail at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) x_q[i] <= '0;
        end else if (rel) begin
            for (int i = 0; i < IN; i++) x_q[i] <= '0;
        end else if (fill_wr) begin
            x_q[idx_q] <= s_data;
        end
    end

    assign x         = x_q;
    assign s_ready   = s_ready_q;
    assign x_valid   = x_valid_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/fc_act_loader.md
Name: fc_act_loader

Overview:
- Producer side of the fully-connected layer's parallel activation input x[0:IN-1].
- Accepts one WIDTH-bit activation per beat over a valid/ready stream from the previous stage, with s_last marking the final beat of a frame.
- Assembles one IN-entry frame, then presents it statically to the combinational FC layer until the downstream controller acknowledges it.
- Sits between the upstream activation stream (conv/pool or previous fc output serializer) and the layer input array.

Parameters:
- WIDTH, 8, activation width in bits; must match the layer's WIDTH.
- IN, 128, activations per frame; must match the layer's IN; minimum 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  WIDTH  activation value, treated as raw bits.
- s_last  in  1  final beat of the frame.
- x  out  WIDTH x [0:IN-1]  unpacked activation array to the layer; x[i] is the i-th accepted beat.
- x_valid  out  1  frame is complete and x is stable.
- x_ready  in  1  downstream has consumed the frame.
- err_short  out  1  one-cycle pulse: s_last arrived before IN beats.
- err_long  out  1  one-cycle pulse: IN beats arrived without s_last.
- frame_cnt  out  16  count of frames presented, wraps at 65535->0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, idx=0, all x[i]=0, x_valid=0, err_short=0, err_long=0, frame_cnt=0. s_ready=0 while rst_n=0.
- Handshakes:
  - A beat transfers on a clock edge with s_valid=1 and s_ready=1.
  - A frame is released on a clock edge with x_valid=1 and x_ready=1.
- State FILL:
  - s_ready=1, x_valid=0.
  - Each accepted beat writes x[idx] <= s_data, and idx increments.
  - Accepted beat with s_last=1 and idx<IN-1: go to HOLD; entries idx+1..IN-1 keep their cleared value 0; err_short pulses for 1 cycle (the cycle after the edge).
  - Accepted beat with s_last=1 and idx==IN-1: go to HOLD, no error.
  - Accepted beat with s_last=0 and idx==IN-1: go to DRAIN; err_long pulses for 1 cycle.
- State DRAIN:
  - s_ready=1; beats are discarded and x is not modified.
  - An accepted beat with s_last=1 moves to HOLD.
  - No further err_long pulses for the same frame.
- State HOLD:
  - x_valid=1, s_ready=0; x is held bit-stable.
  - On x_ready=1: all x[i] cleared to 0, idx=0, frame_cnt increments, state returns to FILL. x_valid is 0 and s_ready is 1 in the next cycle.
  - x_ready while x_valid=0 is ignored.
- Latency:
  - x_valid rises on the cycle after the edge that accepts the terminating beat (the last beat in FILL, or s_last in DRAIN).
  - Minimum frame period is IN+1 cycles when s_valid=1 continuously and x_ready is tied high.
- Registers and widths:
  - x, x_valid, s_ready, the err pulses and frame_cnt are all registered; no combinational path from inputs to outputs.
  - idx is $clog2(IN) bits.
- s_valid=1 during HOLD: no transfer; upstream must hold the beat.
- Reset mid-frame discards the partial frame; upstream re-sends from beat 0.
- IN=1 is unsupported.

Test Plan:
- Full frame: after reset, stream s_data=i+1 for i=0..127 with s_last on beat 127 and x_ready=0 -> x_valid=1 exactly 1 cycle after beat 127; x[0]=1, x[127]=128; s_ready=0; no error pulses; x held stable for 20 cycles.
- Release and back-to-back: x_ready pulsed 1 cycle in HOLD, then a second frame of all 8'hFF -> frame_cnt=1; x all zero for the cycle after release; then x all 8'hFF and x_valid=1; period is 129 cycles with continuous s_valid.
- Short frame: 10 beats of 8'h05 with s_last on beat 9 -> err_short pulses once; x[0..9]=5 and x[10..127]=0; x_valid=1.
- Long frame: 130 beats, s_last on beat 129 -> err_long pulses 1 cycle after beat 127; x[127] equals beat 127's data; beats 128-129 discarded; x_valid=1 after beat 129.
- Backpressure and bubbles: randomized s_valid gaps, plus s_valid=1 during HOLD -> no beat is lost or duplicated, and no x entry changes during HOLD.
- Async reset mid-frame: rst_n low for 1 cycle after 50 beats -> x all 0, x_valid=0, frame_cnt=0 immediately; a following full frame loads correctly from x[0].
